// File: rtl/shift_right_serial_pkg.sv
// Shared datapath constants for the right-shift unit: state encoding, widths,
// and the shift funct codes the control unit decodes into arith_i.
package shift_right_serial_pkg;

  localparam int DP_WIDTH   = 32;
  localparam int DP_SHAMT_W = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;

  // Arithmetic variants are the odd codes; control uses this to drive arith_i.
  function automatic logic is_arith_funct(input logic [5:0] funct);
    return (funct == FUNCT_SRA) || (funct == FUNCT_SRAV);
  endfunction

  function automatic logic is_variable_funct(input logic [5:0] funct);
    return (funct == FUNCT_SRLV) || (funct == FUNCT_SRAV);
  endfunction

endpackage

// File: rtl/shift_right_one_bit.sv
// Combinational single-position right shift with an explicit fill bit.
module shift_right_one_bit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data,
  input  logic             fill,
  output logic [WIDTH-1:0] result
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_bit
      assign result[gi] = data[gi+1];
    end
  endgenerate

  assign result[WIDTH-1] = fill;

endmodule

// File: rtl/shift_right_serial.sv
// Multi-cycle SRL/SRA unit: one bit per clock, Moore handshake via
// ready_o/busy_o/done_o, result held in data_o until the next completion.
module shift_right_serial
  import shift_right_serial_pkg::*;
#(
  parameter int WIDTH   = DP_WIDTH,
  parameter int SHAMT_W = DP_SHAMT_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               arith_i,
  output logic               ready_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH-1:0]   data_o
);

  state_t             state_reg;
  logic [WIDTH-1:0]   shift_reg;
  logic [SHAMT_W-1:0] cnt_reg;
  logic               fill_reg;
  logic [WIDTH-1:0]   shift_next;

  shift_right_one_bit #(
    .WIDTH (WIDTH)
  ) u_one_bit (
    .data   (shift_reg),
    .fill   (fill_reg),
    .result (shift_next)
  );

  // Handshake outputs are registered together with the state so they are
  // exactly the decode of state_reg and never see an input combinationally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      cnt_reg   <= '0;
      fill_reg  <= 1'b0;
      data_o    <= '0;
      ready_o   <= 1'b1;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            shift_reg <= data_i;
            cnt_reg   <= shamt_i;
            fill_reg  <= arith_i & data_i[WIDTH-1];
            ready_o   <= 1'b0;
            busy_o    <= 1'b1;
            if (shamt_i == '0) begin
              state_reg <= DONE;
              data_o    <= data_i;
              done_o    <= 1'b1;
            end else begin
              state_reg <= SHIFT;
            end
          end
        end
        SHIFT: begin
          shift_reg <= shift_next;
          cnt_reg   <= cnt_reg - SHAMT_W'(1);
          if (cnt_reg == SHAMT_W'(1)) begin
            state_reg <= DONE;
            data_o    <= shift_next;
            done_o    <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          ready_o   <= 1'b1;
          busy_o    <= 1'b0;
          done_o    <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          ready_o   <= 1'b1;
          busy_o    <= 1'b0;
          done_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_right_serial.sv
// Directed bench for shift_right_serial: timing, fill modes, ignored starts,
// and reset abort, each checked against hand-computed values.
module tb_shift_right_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] data;
  logic [4:0]  shamt;
  logic        arith;
  logic        ready_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] data_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shift_right_serial #(
    .WIDTH   (32),
    .SHAMT_W (5)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .data_i  (data),
    .shamt_i (shamt),
    .arith_i (arith),
    .ready_o (ready_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .data_o  (data_o)
  );

  // Presents a request for one edge, then scrambles the inputs so only the
  // captured copies can produce the right answer. Returns #1 into cycle 1.
  task automatic issue(input logic [31:0] d, input logic [4:0] s, input logic a);
    start = 1'b1;
    data  = d;
    shamt = s;
    arith = a;
    @(posedge clk);
    #1;
    start = 1'b0;
    data  = $urandom;
    shamt = 5'($urandom);
    arith = 1'($urandom);
  endtask

  // Walks cycles until done_o (bounded); lat is the 1-based cycle index.
  task automatic wait_done(output int lat, output int busy_bad);
    lat      = 1;
    busy_bad = 0;
    while (done_o !== 1'b1 && lat < 100) begin
      if (busy_o !== 1'b1 || ready_o !== 1'b0) busy_bad++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (busy_o !== 1'b1 || ready_o !== 1'b0) busy_bad++;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (ready_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: ready/busy/done=%b%b%b required 100", ready_o, busy_o, done_o);
    end
    n_vec++;
    if (data_o !== 32'h0) begin
      n_err++;
      $display("FAIL reset_data: data_o=%h required 00000000", data_o);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (ready_o !== 1'b1 || done_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: ready=%b done=%b required 1 0", ready_o, done_o);
    end
    $display("reset: ready=%b busy=%b done=%b data_o=%h", ready_o, busy_o, done_o, data_o);
  endtask

  task automatic test_op(input string name, input logic [31:0] d, input logic [4:0] s,
                         input logic a, input logic [31:0] exp);
    int lat;
    int busy_bad;
    issue(d, s, a);
    wait_done(lat, busy_bad);
    n_vec++;
    if (lat !== int'(s) + 1) begin
      n_err++;
      $display("FAIL %s_latency: done_o in cycle %0d required %0d", name, lat, int'(s) + 1);
    end
    n_vec++;
    if (data_o !== exp) begin
      n_err++;
      $display("FAIL %s_data: data_o=%h required %h", name, data_o, exp);
    end
    n_vec++;
    if (busy_bad != 0) begin
      n_err++;
      $display("FAIL %s_busy: %0d cycles with busy/ready wrong, required 0", name, busy_bad);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (ready_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s_return: ready/busy/done=%b%b%b required 100", name, ready_o, busy_o, done_o);
    end
    n_vec++;
    if (data_o !== exp) begin
      n_err++;
      $display("FAIL %s_hold: data_o=%h required %h", name, data_o, exp);
    end
    $display("%s: d=%h shamt=%0d arith=%b -> data_o=%h latency=%0d", name, d, s, a, data_o, lat);
  endtask

  task automatic test_ignored_start();
    int ndone    = 0;
    int done_cyc = 0;
    int busy_bad = 0;
    int ready_bad = 0;
    logic [31:0] data_at_done = 32'h0;
    issue(32'hF0F0F0F0, 5'd8, 1'b0);
    for (int cyc = 1; cyc <= 15; cyc++) begin
      if (done_o === 1'b1) begin
        ndone++;
        done_cyc     = cyc;
        data_at_done = data_o;
      end
      if (cyc <= 9 && busy_o !== 1'b1) busy_bad++;
      if (cyc == 10 && ready_o !== 1'b1) ready_bad++;
      if (cyc == 3 || cyc == 9) begin
        start = 1'b1;
        data  = 32'hFFFFFFFF;
        shamt = 5'd1;
        arith = 1'b0;
      end
      if (cyc == 4 || cyc == 10) start = 1'b0;
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (ndone != 1 || done_cyc != 9) begin
      n_err++;
      $display("FAIL ignore_done: %0d pulses, last in cycle %0d, required 1 in cycle 9", ndone, done_cyc);
    end
    n_vec++;
    if (data_at_done !== 32'h00F0F0F0) begin
      n_err++;
      $display("FAIL ignore_data: data_o=%h required 00f0f0f0", data_at_done);
    end
    n_vec++;
    if (busy_bad != 0 || ready_bad != 0) begin
      n_err++;
      $display("FAIL ignore_busy: busy_bad=%0d ready_bad=%0d required 0 0", busy_bad, ready_bad);
    end
    n_vec++;
    if (data_o !== 32'h00F0F0F0 || ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL ignore_end: data_o=%h ready=%b required 00f0f0f0 1", data_o, ready_o);
    end
    $display("ignored_start: done pulses=%0d data_o=%h", ndone, data_at_done);
  endtask

  task automatic test_reset_mid_shift();
    int ndone = 0;
    issue(32'hAAAA5555, 5'd20, 1'b1);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (done_o === 1'b1) ndone++;
      if (cyc == 10) rst = 1'b1;
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (ready_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_err++;
      $display("FAIL abort_flags: ready/busy/done=%b%b%b required 100", ready_o, busy_o, done_o);
    end
    n_vec++;
    if (data_o !== 32'h0) begin
      n_err++;
      $display("FAIL abort_data: data_o=%h required 00000000", data_o);
    end
    rst = 1'b0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      if (done_o === 1'b1) ndone++;
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (ndone != 0 || ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL abort_nodone: %0d pulses ready=%b required 0 pulses ready=1", ndone, ready_o);
    end
    $display("reset_mid_shift: aborted, done pulses=%0d data_o=%h", ndone, data_o);
    test_op("after_abort", 32'h0000FF00, 5'd8, 1'b0, 32'h000000FF);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    data  = 32'h0;
    shamt = 5'd0;
    arith = 1'b0;
    test_reset();
    test_op("srl4",     32'h80000000, 5'd4,  1'b0, 32'h08000000);
    test_op("sra4",     32'h80000000, 5'd4,  1'b1, 32'hF8000000);
    test_op("sra0",     32'h12345678, 5'd0,  1'b1, 32'h12345678);
    test_op("sra31",    32'h80000001, 5'd31, 1'b1, 32'hFFFFFFFF);
    test_op("srl31",    32'h80000001, 5'd31, 1'b0, 32'h00000001);
    test_op("sra_pos",  32'h40000000, 5'd2,  1'b1, 32'h10000000);
    test_ignored_start();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
